// File: rtl/track_section_arbiter.sv
// rtl/track_section_arbiter.sv - round-robin track section arbiter; optional hold watchdog via TRACK_WATCHDOG_EN
module track_section_arbiter #(
    parameter int NTRAIN       = 2,
    parameter int SETTLE_CYC   = 4,
    parameter int CLEAR_CYC    = 2,
    parameter int HOLD_TIMEOUT = 64
) (
    input  logic              Clock,
    input  logic              RESET,
    input  logic [NTRAIN-1:0] REQ,
    input  logic [NTRAIN-1:0] EXIT,
    output logic [NTRAIN-1:0] GO,
    output logic [1:0]        ROUTE,
    output logic              BUSY,
    output logic              FAULT
);

    localparam int MAX_SC = (SETTLE_CYC > CLEAR_CYC) ? SETTLE_CYC : CLEAR_CYC;
    localparam int MAX_ALL = (MAX_SC > HOLD_TIMEOUT) ? MAX_SC : HOLD_TIMEOUT;
    localparam int CW = $clog2(MAX_ALL + 1);
    localparam logic [CW-1:0] SETTLE_LD = CW'(SETTLE_CYC - 1);
    localparam logic [CW-1:0] CLEAR_LD  = CW'(CLEAR_CYC - 1);
`ifdef TRACK_WATCHDOG_EN
    localparam logic [CW-1:0] HOLD_LAST = CW'(HOLD_TIMEOUT - 1);
`endif

    typedef enum logic [2:0] {
        S_IDLE,
        S_SETTLE,
        S_HOLD,
        S_CLEAR,
        S_FAULT
    } state_t;

    state_t          state;
    logic [CW-1:0]   cnt;
    logic [1:0]      rr;
    logic [1:0]      win;
    logic [1:0]      rr_next;
    logic            owner_exit;
    int              scan_idx;

    // Round-robin pick: scan downward so the offset closest to rr is assigned last and wins
    always_comb begin
        win      = rr;
        scan_idx = 0;
        for (int k = NTRAIN - 1; k >= 0; k--) begin
            scan_idx = int'(rr) + k;
            if (scan_idx >= NTRAIN) scan_idx = scan_idx - NTRAIN;
            if (REQ[scan_idx]) win = 2'(scan_idx);
        end
    end

    // GO is one-hot on the owner during HOLD, so masking EXIT with it isolates the owner's sensor
    assign owner_exit = |(EXIT & GO);
    assign rr_next    = (ROUTE == 2'(NTRAIN - 1)) ? 2'd0 : ROUTE + 2'd1;

`ifndef TRACK_WATCHDOG_EN
    assign FAULT = 1'b0;
`endif

    // Arbitration FSM with registered GO/ROUTE/BUSY (and FAULT when the watchdog is built in)
    always_ff @(posedge Clock or negedge RESET) begin
        if (!RESET) begin
            state <= S_IDLE;
            GO    <= '0;
            ROUTE <= 2'd0;
            BUSY  <= 1'b0;
            rr    <= 2'd0;
            cnt   <= '0;
`ifdef TRACK_WATCHDOG_EN
            FAULT <= 1'b0;
`endif
        end else begin
            case (state)
                S_IDLE: begin
                    if (|REQ) begin
                        ROUTE <= win;
                        cnt   <= SETTLE_LD;
                        BUSY  <= 1'b1;
                        state <= S_SETTLE;
                    end
                end
                S_SETTLE: begin
                    if (cnt == '0) begin
                        GO    <= NTRAIN'(1) << ROUTE;
                        state <= S_HOLD;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                S_HOLD: begin
                    if (owner_exit) begin
                        GO    <= '0;
                        cnt   <= CLEAR_LD;
                        state <= S_CLEAR;
`ifdef TRACK_WATCHDOG_EN
                    end else if (cnt == HOLD_LAST) begin
                        GO    <= '0;
                        FAULT <= 1'b1;
                        state <= S_FAULT;
                    end else begin
                        cnt <= cnt + 1'b1;
`endif
                    end
                end
                S_CLEAR: begin
                    if (cnt == '0) begin
                        BUSY  <= 1'b0;
                        rr    <= rr_next;
                        state <= S_IDLE;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                S_FAULT: begin
                    state <= S_FAULT;
                end
                default: begin
                    GO    <= '0;
                    BUSY  <= 1'b0;
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/track_section_arbiter.md
Name: track_section_arbiter

Overview:
- Shares one track section (crossing/merge) among NTRAIN trains.
- Each train raises a level request from its approach sensor and releases the section through its exit sensor.
- The block picks a winner round-robin and drives the route-select (switch setting) to that train. It waits a switch-settle time, grants GO, then enforces a clearance gap before the next grant.
- Sits above the per-train speed/direction and switch FSMs; its GO and ROUTE outputs feed them.

Parameters:
- NTRAIN, 2: number of requesting trains, legal range 2..4.
- SETTLE_CYC, 4: cycles between route change and GO, minimum 1.
- CLEAR_CYC, 2: clearance cycles after exit before the next arbitration, minimum 1.
- HOLD_TIMEOUT, 64: maximum HOLD cycles without exit. Used only with TRACK_WATCHDOG_EN.

Ports:
- Clock, input, 1: single system clock, rising edge.
- RESET, input, 1: asynchronous, active-low reset.
- REQ, input, NTRAIN: level request per train, held until granted.
- EXIT, input, NTRAIN: per-train exit sensor, pulse or level.
- GO, output, NTRAIN: one-hot grant, registered.
- ROUTE, output, 2: index of the current/last owner, drives switch setting.
- BUSY, output, 1: high in every state except IDLE.
- FAULT, output, 1: watchdog fault, sticky.

Behaviour:
- RESET low, asynchronous: state IDLE, GO=0, ROUTE=0, BUSY=0, FAULT=0, rr pointer=0, counters=0. GO drops immediately even mid-HOLD.
- States: IDLE, SETTLE, HOLD, CLEAR, plus FAULT with the macro. Outputs decode from registered state/owner only, never combinationally from inputs.
- IDLE, any REQ high at an edge:
  - Winner is the first set REQ bit scanning from rr pointer upward, wrapping modulo NTRAIN.
  - Same edge: owner and ROUTE=winner latched, counter loaded with SETTLE_CYC-1, go to SETTLE.
- SETTLE:
  - Counter decrements each edge. At 0, go to HOLD.
  - Result: GO[owner]=1 exactly SETTLE_CYC edges after the request was sampled.
  - REQ deassertion during SETTLE is ignored; the grant completes.
- HOLD:
  - GO[owner]=1. REQ changes are ignored.
  - EXIT[owner] high at an edge: go to CLEAR, GO=0 after that edge.
  - EXIT bits of non-owners are ignored.
- CLEAR:
  - Counter loaded with CLEAR_CYC-1 on entry; at 0, go to IDLE.
  - On leaving: rr pointer = (owner+1) mod NTRAIN.
  - ROUTE holds the last owner through CLEAR and IDLE.
- Simultaneous requests: the train nearest the pointer wins; the others stay pending, since REQ is a level. A loser is served no later than NTRAIN-1 grants later.
- REQ arriving during SETTLE/HOLD/CLEAR waits for IDLE. There is no queueing beyond the REQ level.
- Arbitration only in IDLE, so re-arbitration earliest CLEAR_CYC edges after the exit edge.
- Counter width: clog2 of max(SETTLE_CYC, CLEAR_CYC, HOLD_TIMEOUT)+1.
- ROUTE width is fixed at 2; the upper bit is 0 when NTRAIN=2.

Optional Feature:
- Macro: TRACK_WATCHDOG_EN.
- Defined:
  - HOLD counts cycles. If HOLD_TIMEOUT cycles elapse without EXIT[owner], go to FAULT.
  - In FAULT: GO=0, FAULT=1, BUSY=1, ROUTE held. Exit only via RESET.
  - EXIT on the same edge as the timeout wins; go to CLEAR, no fault.
- Undefined: FAULT tied 0, no timeout counter, HOLD waits indefinitely.

Test Plan:
- Single request: reset released, REQ=01 sampled at edge E. Response: ROUTE=0 and BUSY=1 after E, GO=01 after E+4. EXIT=01 at F gives GO=00 after F, BUSY=0 after F+2.
- Simultaneous: REQ=11 held from reset with pointer=0. Response: train 0 granted first. After its exit plus clearance, train 1 granted with ROUTE=1 and GO=10.
- Fairness: REQ=11 held continuously, exits issued promptly. Response: GO alternates 01,10,01,10 over four grants.
- Foreign exit: train 0 in HOLD, EXIT=10. Response: GO stays 01 and state stays HOLD; EXIT=01 then releases.
- Async reset mid-HOLD: RESET low between edges while GO=01. Response: GO=00 and BUSY=0 before the next edge; after release, the first grant goes to train 0.
- Watchdog (TRACK_WATCHDOG_EN, HOLD_TIMEOUT=64): grant train 1, never exit. Response: after 64 HOLD cycles GO=00 and FAULT=1; FAULT stays 1 under further REQ/EXIT until RESET.
